// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-memory loader.
//   loader_state_t : loader FSM state encoding
//   DEFAULT_DEPTH  : default instruction-memory depth in 32-bit words
//   WORD_W         : instruction word width
package cpu_pkg;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        DONE,
        ERR
    } loader_state_t;

    localparam int DEFAULT_DEPTH = 128;
    localparam int WORD_W        = 32;

endpackage

// File: rtl/word_packer.sv
// Big-endian byte-to-word assembler.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous clear of the partial word and byte counter
//   byte_en    : accept byte_in this cycle
//   byte_in    : incoming byte (first byte of a word lands in bits 31:24)
//   word       : assembled word, meaningful while word_valid=1
//   word_valid : combinational pulse on the 4th accepted byte of a word
module word_packer
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [23:0] shreg;
    logic [1:0]  byte_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (clr) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (byte_en) begin
            shreg    <= {shreg[15:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // The 4th byte is never stored; it is appended here so the loader can
    // register the full word on the same edge that accepts it.
    assign word       = {shreg, byte_in};
    assign word_valid = byte_en && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a program from a serial byte stream into instruction memory.
// Stream: 16-bit big-endian word count N, then N big-endian 32-bit words.
//   clk, rst   : clock, asynchronous active-high reset
//   in_data    : program byte, in_valid qualifies it, in_ready accepts it
//   reload     : restart request, honoured only in DONE or ERR
//   mem_we     : one-cycle write strobe per word, with mem_addr/mem_wdata
//   cpu_rst    : holds the CPU in reset until the program is loaded
//   done       : program fully loaded
//   error      : header word count exceeded DEPTH
module imem_loader
    import cpu_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    loader_state_t     state;
    logic [15:0]       count;
    logic [ADDR_W-1:0] word_idx;
    logic              xfer;
    logic [15:0]       hdr_count;
    logic              last_word;
    logic [WORD_W-1:0] word;
    logic              word_valid;

    assign in_ready  = (state == HDR_HI) || (state == HDR_LO) || (state == DATA);
    assign done      = (state == DONE);
    assign error     = (state == ERR);
    assign xfer      = in_valid && in_ready;
    assign hdr_count = {count[15:8], in_data};
    assign last_word = (16'(word_idx) == count - 16'd1);

    // Holding the packer in clear outside DATA guarantees every load starts
    // on a word boundary.
    word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (state != DATA),
        .byte_en    (xfer && (state == DATA)),
        .byte_in    (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HDR_HI;
            count     <= '0;
            word_idx  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst   <= 1'b1;
        end else begin
            mem_we  <= 1'b0;
            // Released only once DONE has been held for a cycle, so it trails
            // the final write strobe; a reload re-asserts it immediately.
            cpu_rst <= !((state == DONE) && !reload);
            case (state)
                HDR_HI: begin
                    if (xfer) begin
                        count[15:8] <= in_data;
                        state       <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        count[7:0] <= in_data;
                        word_idx   <= '0;
                        if (hdr_count > 16'(DEPTH))
                            state <= ERR;
                        else if (hdr_count == 16'd0)
                            state <= DONE;
                        else
                            state <= DATA;
                    end
                end
                DATA: begin
                    if (word_valid) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= word_idx;
                        mem_wdata <= word;
                        word_idx  <= word_idx + 1'b1;
                        if (last_word)
                            state <= DONE;
                    end
                end
                DONE, ERR: begin
                    if (reload) begin
                        state    <= HDR_HI;
                        count    <= '0;
                        word_idx <= '0;
                    end
                end
                default: state <= HDR_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    imem_loader #(.DEPTH(128), .ADDR_W(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .reload    (reload),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t wq[$];

    always @(negedge clk) begin
        if (!rst && mem_we) wq.push_back('{a: mem_addr, d: mem_wdata});
    end

    typedef struct {
        logic        rst;
        logic        v;
        logic [7:0]  d;
        logic        rl;
        logic [43:0] exp;
    } vec_t;

    vec_t tbl[28];

    // {in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, error}
    function automatic logic [43:0] o(logic rdy, logic we, logic [6:0] a,
                                      logic [31:0] d, logic cpu, logic dn, logic er);
        return {rdy, we, a, d, cpu, dn, er};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            reload   = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        reload = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wq.delete();
    endtask

    function automatic logic [31:0] wd(input int k);
        logic [7:0] kb;
        kb = 8'(k);
        return {kb, 8'hA5, ~kb, kb + 8'd3};
    endfunction

    localparam logic [31:0] W0 = 32'h2001_0005;
    localparam logic [31:0] W1 = 32'hAC01_0000;

    initial begin
        logic [38:0] first;

        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, o(1, 0, 0, 0,  1, 0, 0)};
        tbl[1]  = '{1'b0, 1'b1, 8'h00, 1'b0, o(1, 0, 0, 0,  1, 0, 0)};
        tbl[2]  = '{1'b0, 1'b1, 8'h02, 1'b0, o(1, 0, 0, 0,  1, 0, 0)};
        tbl[3]  = '{1'b0, 1'b1, 8'h20, 1'b0, o(1, 0, 0, 0,  1, 0, 0)};
        tbl[4]  = '{1'b0, 1'b1, 8'h01, 1'b0, o(1, 0, 0, 0,  1, 0, 0)};
        tbl[5]  = '{1'b0, 1'b1, 8'h00, 1'b0, o(1, 0, 0, 0,  1, 0, 0)};
        tbl[6]  = '{1'b0, 1'b1, 8'h05, 1'b0, o(1, 1, 0, W0, 1, 0, 0)};
        tbl[7]  = '{1'b0, 1'b1, 8'hAC, 1'b0, o(1, 0, 0, W0, 1, 0, 0)};
        tbl[8]  = '{1'b0, 1'b1, 8'h01, 1'b0, o(1, 0, 0, W0, 1, 0, 0)};
        tbl[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, o(1, 0, 0, W0, 1, 0, 0)};
        tbl[10] = '{1'b0, 1'b1, 8'h00, 1'b0, o(0, 1, 1, W1, 1, 1, 0)};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, o(0, 0, 1, W1, 0, 1, 0)};
        tbl[12] = '{1'b0, 1'b1, 8'hFF, 1'b0, o(0, 0, 1, W1, 0, 1, 0)};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, o(1, 0, 1, W1, 1, 0, 0)};
        tbl[14] = '{1'b0, 1'b1, 8'h00, 1'b0, o(1, 0, 1, W1, 1, 0, 0)};
        tbl[15] = '{1'b0, 1'b1, 8'h00, 1'b0, o(0, 0, 1, W1, 1, 1, 0)};
        tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b0, o(0, 0, 1, W1, 0, 1, 0)};
        tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b1, o(1, 0, 1, W1, 1, 0, 0)};
        tbl[18] = '{1'b0, 1'b1, 8'h00, 1'b0, o(1, 0, 1, W1, 1, 0, 0)};
        tbl[19] = '{1'b0, 1'b1, 8'h81, 1'b0, o(0, 0, 1, W1, 1, 0, 1)};
        tbl[20] = '{1'b0, 1'b0, 8'h00, 1'b0, o(0, 0, 1, W1, 1, 0, 1)};
        tbl[21] = '{1'b0, 1'b1, 8'h00, 1'b0, o(0, 0, 1, W1, 1, 0, 1)};
        tbl[22] = '{1'b0, 1'b0, 8'h00, 1'b1, o(1, 0, 1, W1, 1, 0, 0)};
        tbl[23] = '{1'b0, 1'b0, 8'h00, 1'b1, o(1, 0, 1, W1, 1, 0, 0)};
        tbl[24] = '{1'b0, 1'b1, 8'h00, 1'b0, o(1, 0, 1, W1, 1, 0, 0)};
        tbl[25] = '{1'b0, 1'b0, 8'h00, 1'b1, o(1, 0, 1, W1, 1, 0, 0)};
        tbl[26] = '{1'b0, 1'b1, 8'h80, 1'b0, o(1, 0, 1, W1, 1, 0, 0)};
        tbl[27] = '{1'b0, 1'b1, 8'hDE, 1'b0, o(1, 0, 1, W1, 1, 0, 0)};

        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            rst      = tbl[i].rst;
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
            reload   = tbl[i].rl;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  64'({in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, error}),
                  64'(tbl[i].exp));
        end

        // One word with a 3-cycle in_valid gap mid-word
        do_reset();
        send(8'h00); send(8'h01); send(8'hDE); send(8'hAD);
        idle(3);
        send(8'hBE); send(8'hEF);
        idle(4);
        check("pause_wr_count", 64'(wq.size()), 64'd1);
        first = (wq.size() > 0) ? {wq[0].a, wq[0].d} : '1;
        check("pause_wr", 64'(first), 64'({7'd0, 32'hDEADBEEF}));
        check("pause_done", 64'({done, cpu_rst, in_ready}), 64'(3'b100));

        // Reset mid-load discards the partial word and count
        do_reset();
        send(8'h00); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h55); send(8'h66);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("async_rst", 64'({mem_we, mem_addr, mem_wdata, cpu_rst, done, error, in_ready}),
              64'({1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1}));
        @(negedge clk);
        rst = 1'b0;
        wq.delete();
        send(8'h00); send(8'h01);
        send(8'h00); send(8'h00); send(8'h00); send(8'h01);
        idle(4);
        check("rst_wr_count", 64'(wq.size()), 64'd1);
        first = (wq.size() > 0) ? {wq[0].a, wq[0].d} : '1;
        check("rst_wr", 64'(first), 64'({7'd0, 32'h00000001}));
        check("rst_done", 64'(done), 64'd1);

        // Full-depth load: N = DEPTH
        do_reset();
        send(8'h00); send(8'h80);
        for (int k = 0; k < 128; k++) begin
            logic [31:0] w;
            w = wd(k);
            send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
        end
        idle(1);
        check("full_last", 64'({mem_we, mem_addr, cpu_rst, done}),
              64'({1'b1, 7'd127, 1'b1, 1'b1}));
        idle(1);
        check("full_cpu_rst", 64'({mem_we, cpu_rst, done, in_ready}), 64'(4'b0010));
        idle(5);
        check("full_wr_count", 64'(wq.size()), 64'd128);
        for (int k = 0; k < 128; k++) begin
            first = (k < wq.size()) ? {wq[k].a, wq[k].d} : '1;
            check($sformatf("full_wr%0d", k), 64'(first), 64'({7'(k), wd(k)}));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
